// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, stimulus test order, LFSR mask and checker types.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned NUM_OPS = 7;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] OP_AND = 4'b0100;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0101;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0110;
  localparam logic [OP_W-1:0] OP_NOR = 4'b0111;
  localparam logic [OP_W-1:0] OP_SLT = 4'b1010;

  // Index 0 is applied first for every operand pair.
  localparam logic [NUM_OPS-1:0][OP_W-1:0] OP_ORDER =
    {OP_SLT, OP_NOR, OP_XOR, OP_OR, OP_AND, OP_SUB, OP_ADD};

  localparam logic [DATA_W-1:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [DATA_W-1:0] VEC0_A    = 32'h8000_0000;
  localparam logic [DATA_W-1:0] VEC0_B    = 32'h0000_0001;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] result;
    logic [OP_W-1:0]   op;
  } fail_t;

  // Galois LFSR, shift right.
  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] x);
    return x[0] ? ((x >> 1) ^ LFSR_MASK) : (x >> 1);
  endfunction

endpackage

// File: rtl/alu_stim_checker_if.sv
// Operand/result bus between the stimulus checker (master) and the ALU under test (slave).
interface alu_stim_checker_if;
  import alu_pkg::*;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  modport master (output alu_a, alu_b, alu_op, input alu_result, alu_zero);
  modport slave  (input alu_a, alu_b, alu_op, output alu_result, alu_zero);
endinterface

// File: rtl/alu_golden.sv
// Combinational reference ALU used to judge the device under test.
module alu_golden
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  logic [DATA_W-1:0] diff;
  assign diff = a - b;

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = diff;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLT:  result = DATA_W'(diff[DATA_W-1]);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_stim_checker.sv
// Drives LFSR operand pairs through every opcode and checks the ALU against alu_golden.
// Optional ALU_ZERO_CHECK_EN also checks the zero flag.
module alu_stim_checker
  import alu_pkg::*;
#(
  parameter int unsigned       NUM_VECTORS = 16,
  parameter logic [DATA_W-1:0] SEED        = 32'h1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  alu_stim_checker_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [DATA_W-1:0]   fail_a,
  output logic [DATA_W-1:0]   fail_b,
  output logic [DATA_W-1:0]   fail_result,
  output logic [OP_W-1:0]     fail_op
);

  localparam int unsigned ERR_W    = 16;
  localparam int unsigned VEC_W    = 13;
  localparam int unsigned OPI_W    = 3;
  localparam logic [DATA_W-1:0] SEED_EFF = (SEED == '0) ? 32'h1 : SEED;
  localparam logic [VEC_W-1:0]  LAST_VEC = VEC_W'(NUM_VECTORS - 1);
  localparam logic [OPI_W-1:0]  LAST_OP  = OPI_W'(NUM_OPS - 1);

  state_t              state, state_d;
  logic [OPI_W-1:0]    op_idx, op_idx_d;
  logic [VEC_W-1:0]    vec_idx, vec_idx_d;
  logic [DATA_W-1:0]   vec_a, vec_a_d, vec_b, vec_b_d;
  logic [DATA_W-1:0]   lfsr, lfsr_d;
  logic [DATA_W-1:0]   drv_a, drv_a_d, drv_b, drv_b_d;
  logic [OP_W-1:0]     drv_op, drv_op_d;
  logic [ERR_W-1:0]    err_d;
  fail_t               fail_q, fail_d;
  logic                busy_d, done_d, pass_d;

  logic [DATA_W-1:0]   lfsr_a_c, lfsr_b_c;
  logic [DATA_W-1:0]   gold_result;
  logic                gold_zero;
  logic                mismatch_c;

  assign bus.alu_a  = drv_a;
  assign bus.alu_b  = drv_b;
  assign bus.alu_op = drv_op;

  assign fail_a      = fail_q.a;
  assign fail_b      = fail_q.b;
  assign fail_result = fail_q.result;
  assign fail_op     = fail_q.op;

  assign lfsr_a_c = lfsr_step(lfsr);
  assign lfsr_b_c = lfsr_step(lfsr_a_c);

  alu_golden u_golden (
    .a      (drv_a),
    .b      (drv_b),
    .op     (drv_op),
    .result (gold_result),
    .zero   (gold_zero)
  );

`ifdef ALU_ZERO_CHECK_EN
  assign mismatch_c = (bus.alu_result != gold_result) || (bus.alu_zero != gold_zero);
`else
  logic unused_zero;
  assign unused_zero = bus.alu_zero ^ gold_zero;
  assign mismatch_c  = (bus.alu_result != gold_result);
`endif

  // Next-state and next-register values.
  always_comb begin
    state_d   = state;
    op_idx_d  = op_idx;
    vec_idx_d = vec_idx;
    vec_a_d   = vec_a;
    vec_b_d   = vec_b;
    lfsr_d    = lfsr;
    drv_a_d   = drv_a;
    drv_b_d   = drv_b;
    drv_op_d  = drv_op;
    err_d     = err_count;
    fail_d    = fail_q;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d   = DRIVE;
          op_idx_d  = '0;
          vec_idx_d = '0;
          vec_a_d   = VEC0_A;
          vec_b_d   = VEC0_B;
          lfsr_d    = SEED_EFF;
          err_d     = '0;
          fail_d    = '0;
        end
      end
      DRIVE: begin
        drv_a_d  = vec_a;
        drv_b_d  = vec_b;
        drv_op_d = OP_ORDER[op_idx];
        state_d  = CHECK;
      end
      CHECK: begin
        if (mismatch_c) begin
          if (err_count != '1) err_d = err_count + ERR_W'(1);
          if (err_count == '0) fail_d = '{a: drv_a, b: drv_b, result: bus.alu_result, op: drv_op};
        end
        if (op_idx == LAST_OP && vec_idx == LAST_VEC) begin
          state_d = DONE;
        end else begin
          state_d = DRIVE;
          if (op_idx == LAST_OP) begin
            op_idx_d  = '0;
            vec_idx_d = vec_idx + VEC_W'(1);
            vec_a_d   = lfsr_a_c;
            vec_b_d   = lfsr_b_c;
            lfsr_d    = lfsr_b_c;
          end else begin
            op_idx_d = op_idx + OPI_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DRIVE) || (state_d == CHECK);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_idx    <= '0;
      vec_idx   <= '0;
      vec_a     <= '0;
      vec_b     <= '0;
      lfsr      <= SEED_EFF;
      drv_a     <= '0;
      drv_b     <= '0;
      drv_op    <= '0;
      err_count <= '0;
      fail_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= state_d;
      op_idx    <= op_idx_d;
      vec_idx   <= vec_idx_d;
      vec_a     <= vec_a_d;
      vec_b     <= vec_b_d;
      lfsr      <= lfsr_d;
      drv_a     <= drv_a_d;
      drv_b     <= drv_b_d;
      drv_op    <= drv_op_d;
      err_count <= err_d;
      fail_q    <= fail_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
    end
  end

endmodule
